// File: rtl/ym_bus_sequencer.sv
// ============================================================================
//  Module      : ym_bus_sequencer
//  Description : Owns the shared BDIR/BC1/DA bus of a dual YM2149 pair.
//                Round-robin arbitration between a CPU and a DMA requester;
//                each request becomes address-latch -> gap -> data-write ->
//                gap, with programmable phase lengths and chip select.
//  Option      : YM_ADDR_CACHE_EN - skip the address phase when the granted
//                {chip,reg} equals the last latched one.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ym_bus_sequencer #(
    parameter int ADDR_HOLD_CYC = 2,
    parameter int DATA_HOLD_CYC = 2,
    parameter int IDLE_GAP_CYC  = 1
) (
    input  logic       cpu_clock,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_chip,
    input  logic [3:0] cpu_reg,
    input  logic [7:0] cpu_data,
    output logic       cpu_ack,
    input  logic       dma_req,
    input  logic       dma_chip,
    input  logic [3:0] dma_reg,
    input  logic [7:0] dma_data,
    output logic       dma_ack,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] da_out,
    output logic       da_oe,
    output logic       ym_0,
    output logic       ym_1,
    output logic       busy
);

    // Phase counter sized from the longest programmable phase
    localparam int MAX_AD  = (ADDR_HOLD_CYC > DATA_HOLD_CYC) ? ADDR_HOLD_CYC : DATA_HOLD_CYC;
    localparam int MAX_CYC = (MAX_AD > IDLE_GAP_CYC) ? MAX_AD : IDLE_GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] c_addr_load = CW'(ADDR_HOLD_CYC - 1);
    localparam logic [CW-1:0] c_data_load = CW'(DATA_HOLD_CYC - 1);
    localparam logic [CW-1:0] c_gap_load  = CW'(IDLE_GAP_CYC - 1);
    localparam logic [CW-1:0] c_one       = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_GAP1 = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP2 = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic            r_last_dma;    // 1: DMA was granted most recently
    logic            r_owner_dma;   // requester of the transaction in flight
    logic [3:0]      r_reg;
    logic [7:0]      r_data;

    logic            w_grant;
    logic            w_grant_dma;
    logic            w_sel_chip;
    logic [3:0]      w_sel_reg;
    logic [7:0]      w_sel_data;
    logic [3:0]      w_cur_reg;
    logic [7:0]      w_cur_data;
    logic            w_ack_nx;

`ifdef YM_ADDR_CACHE_EN
    logic            r_tag_vld;
    logic [4:0]      r_tag;
    logic            w_tag_hit;
`endif

    // Request selection: a lone requester wins; when both pend, the one not served last wins
    always_comb begin
        w_grant     = (r_state == ST_IDLE) && (cpu_req || dma_req);
        w_grant_dma = dma_req && (!cpu_req || !r_last_dma);
        w_sel_chip  = w_grant_dma ? dma_chip : cpu_chip;
        w_sel_reg   = w_grant_dma ? dma_reg  : cpu_reg;
        w_sel_data  = w_grant_dma ? dma_data : cpu_data;
        // While idle the fields being granted are still on the inputs, not yet captured
        w_cur_reg   = (r_state == ST_IDLE) ? w_sel_reg  : r_reg;
        w_cur_data  = (r_state == ST_IDLE) ? w_sel_data : r_data;
    end

`ifdef YM_ADDR_CACHE_EN
    // The address latch of the target chip already holds this register
    assign w_tag_hit = r_tag_vld && (r_tag == {w_sel_chip, w_sel_reg});
`endif

    // Next-state and phase-counter logic
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
`ifdef YM_ADDR_CACHE_EN
                    if (w_tag_hit) begin
                        w_state_nx = ST_DATA;
                        w_cnt_nx   = c_data_load;
                    end else begin
                        w_state_nx = ST_ADDR;
                        w_cnt_nx   = c_addr_load;
                    end
`else
                    w_state_nx = ST_ADDR;
                    w_cnt_nx   = c_addr_load;
`endif
                end
            end
            ST_ADDR: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_GAP1;
                    w_cnt_nx   = c_gap_load;
                end else begin
                    w_cnt_nx   = r_cnt - c_one;
                end
            end
            ST_GAP1: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_DATA;
                    w_cnt_nx   = c_data_load;
                end else begin
                    w_cnt_nx   = r_cnt - c_one;
                end
            end
            ST_DATA: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_GAP2;
                    w_cnt_nx   = c_gap_load;
                end else begin
                    w_cnt_nx   = r_cnt - c_one;
                end
            end
            ST_GAP2: begin
                if (r_cnt == '0) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx   = r_cnt - c_one;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
        // Acknowledge lands on the final gap cycle of the transaction
        w_ack_nx = (w_state_nx == ST_GAP2) && (w_cnt_nx == '0);
    end

    // State and phase-counter registers
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Capture the granted transaction and the arbitration history
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            r_last_dma  <= 1'b1;
            r_owner_dma <= 1'b0;
            r_reg       <= '0;
            r_data      <= '0;
            ym_0        <= 1'b1;
        end else if (w_grant) begin
            r_last_dma  <= w_grant_dma;
            r_owner_dma <= w_grant_dma;
            r_reg       <= w_sel_reg;
            r_data      <= w_sel_data;
            ym_0        <= ~w_sel_chip;
        end
    end

`ifdef YM_ADDR_CACHE_EN
    // Remember which {chip,reg} the last address latch targeted
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            r_tag_vld <= 1'b0;
            r_tag     <= '0;
        end else if (w_grant) begin
            r_tag_vld <= 1'b1;
            r_tag     <= {w_sel_chip, w_sel_reg};
        end
    end
`endif

    // Registered bus outputs derived from the state being entered
    always_ff @(posedge cpu_clock or negedge reset) begin
        if (!reset) begin
            bdir    <= 1'b0;
            bc1     <= 1'b0;
            da_oe   <= 1'b0;
            da_out  <= '0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
        end else begin
            bdir    <= (w_state_nx == ST_ADDR) || (w_state_nx == ST_DATA);
            bc1     <= (w_state_nx == ST_ADDR);
            da_oe   <= (w_state_nx != ST_IDLE);
            cpu_ack <= w_ack_nx && !r_owner_dma;
            dma_ack <= w_ack_nx &&  r_owner_dma;
            if (w_state_nx == ST_ADDR) begin
                da_out <= {4'h0, w_cur_reg};
            end else if (w_state_nx == ST_DATA) begin
                da_out <= w_cur_data;
            end
        end
    end

    assign ym_1 = ~ym_0;
    assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ym_bus_sequencer.sv
// ============================================================================
//  Module      : tb_ym_bus_sequencer
//  Description : Directed self-checking bench for ym_bus_sequencer
//                (default timing 2/2/1). Observed outputs are packed as
//                {bdir,bc1,da_oe,ym_0,ym_1,cpu_ack,dma_ack,busy,da_out}.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ym_bus_sequencer;

    logic       cpu_clock;
    logic       reset;
    logic       cpu_req;
    logic       cpu_chip;
    logic [3:0] cpu_reg;
    logic [7:0] cpu_data;
    logic       cpu_ack;
    logic       dma_req;
    logic       dma_chip;
    logic [3:0] dma_reg;
    logic [7:0] dma_data;
    logic       dma_ack;
    logic       bdir;
    logic       bc1;
    logic [7:0] da_out;
    logic       da_oe;
    logic       ym_0;
    logic       ym_1;
    logic       busy;

    int total;
    int bad;

    ym_bus_sequencer #(
        .ADDR_HOLD_CYC (2),
        .DATA_HOLD_CYC (2),
        .IDLE_GAP_CYC  (1)
    ) dut (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_chip  (cpu_chip),
        .cpu_reg   (cpu_reg),
        .cpu_data  (cpu_data),
        .cpu_ack   (cpu_ack),
        .dma_req   (dma_req),
        .dma_chip  (dma_chip),
        .dma_reg   (dma_reg),
        .dma_data  (dma_data),
        .dma_ack   (dma_ack),
        .bdir      (bdir),
        .bc1       (bc1),
        .da_out    (da_out),
        .da_oe     (da_oe),
        .ym_0      (ym_0),
        .ym_1      (ym_1),
        .busy      (busy)
    );

    initial cpu_clock = 1'b0;
    always #5 cpu_clock = ~cpu_clock;

    // Build an expected output vector; ym_1 is always the complement of ym_0
    function automatic logic [15:0] ev(input logic b, input logic c, input logic oe,
                                       input logic y0, input logic cack, input logic dack,
                                       input logic bsy, input logic [7:0] d);
        return {b, c, oe, y0, ~y0, cack, dack, bsy, d};
    endfunction

    function automatic logic [15:0] obs();
        return {bdir, bc1, da_oe, ym_0, ym_1, cpu_ack, dma_ack, busy, da_out};
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge cpu_clock);
        #1;
    endtask

    // Called in the IDLE cycle where the request is already presented.
    // Checks the six bus cycles and the following IDLE cycle; optionally
    // drops the owning request after checking cycle drop_at.
    task automatic expect_xact(input string tag, input logic chip, input logic [3:0] r,
                               input logic [7:0] d, input logic is_dma, input int drop_at);
        logic       y;
        logic [15:0] e;
        y = ~chip;
        for (int k = 1; k <= 7; k++) begin
            tick();
            case (k)
                1, 2:    e = ev(1'b1, 1'b1, 1'b1, y, 1'b0, 1'b0, 1'b1, {4'h0, r});
                3:       e = ev(1'b0, 1'b0, 1'b1, y, 1'b0, 1'b0, 1'b1, {4'h0, r});
                4, 5:    e = ev(1'b1, 1'b0, 1'b1, y, 1'b0, 1'b0, 1'b1, d);
                6:       e = ev(1'b0, 1'b0, 1'b1, y, !is_dma, is_dma, 1'b1, d);
                default: e = ev(1'b0, 1'b0, 1'b0, y, 1'b0, 1'b0, 1'b0, d);
            endcase
            chk($sformatf("%s_c%0d", tag, k), obs(), e);
            if (k == drop_at) begin
                if (is_dma) dma_req = 1'b0;
                else        cpu_req = 1'b0;
            end
        end
    endtask

`ifdef YM_ADDR_CACHE_EN
    // Address already latched: DATA, DATA, GAP2(ack), IDLE
    task automatic expect_fast(input string tag, input logic chip, input logic [7:0] d,
                               input int drop_at);
        logic        y;
        logic [15:0] e;
        y = ~chip;
        for (int k = 1; k <= 4; k++) begin
            tick();
            case (k)
                1, 2:    e = ev(1'b1, 1'b0, 1'b1, y, 1'b0, 1'b0, 1'b1, d);
                3:       e = ev(1'b0, 1'b0, 1'b1, y, 1'b1, 1'b0, 1'b1, d);
                default: e = ev(1'b0, 1'b0, 1'b0, y, 1'b0, 1'b0, 1'b0, d);
            endcase
            chk($sformatf("%s_c%0d", tag, k), obs(), e);
            if (k == drop_at) cpu_req = 1'b0;
        end
    endtask
`endif

    // Directed sequence
    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        cpu_req  = 1'b0;
        cpu_chip = 1'b0;
        cpu_reg  = 4'h0;
        cpu_data = 8'h00;
        dma_req  = 1'b0;
        dma_chip = 1'b0;
        dma_reg  = 4'h0;
        dma_data = 8'h00;

        // Reset state
        tick();
        tick();
        chk("reset_state", obs(), ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        reset = 1'b1;
        tick();
        chk("idle_after_reset", obs(), ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));

        // 1: CPU chip0 reg7 = 0x38
        cpu_chip = 1'b0; cpu_reg = 4'h7; cpu_data = 8'h38; cpu_req = 1'b1;
        expect_xact("t1_cpu", 1'b0, 4'h7, 8'h38, 1'b0, 6);

        // 2: simultaneous requests from reset: CPU, DMA, CPU
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("t2_idle", obs(), ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        cpu_chip = 1'b0; cpu_reg = 4'h1; cpu_data = 8'hAA; cpu_req = 1'b1;
        dma_chip = 1'b1; dma_reg = 4'h2; dma_data = 8'h55; dma_req = 1'b1;
        expect_xact("t2_cpu_a", 1'b0, 4'h1, 8'hAA, 1'b0, 0);
        expect_xact("t2_dma",   1'b1, 4'h2, 8'h55, 1'b1, 0);
        expect_xact("t2_cpu_b", 1'b0, 4'h1, 8'hAA, 1'b0, 6);
        dma_req = 1'b0;
        tick();
        chk("t2_quiet", obs(), ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA));

        // 3: DMA chip1 reg8 = 0x0F, select stays on chip 1 afterwards
        dma_chip = 1'b1; dma_reg = 4'h8; dma_data = 8'h0F; dma_req = 1'b1;
        expect_xact("t3_dma", 1'b1, 4'h8, 8'h0F, 1'b1, 6);
        tick();
        tick();
        chk("t3_hold_sel", obs(), ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0F));

        // 4: reset during DATA phase
        cpu_chip = 1'b1; cpu_reg = 4'h5; cpu_data = 8'h77; cpu_req = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        chk("t4_in_data", obs(), ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77));
        reset = 1'b0;
        #1;
        chk("t4_async_rst", obs(), ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        cpu_req = 1'b0;
        tick();
        tick();
        chk("t4_rst_hold", obs(), ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        reset = 1'b1;
        tick();
        chk("t4_no_ack", obs(), ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
        cpu_chip = 1'b0; cpu_reg = 4'h9; cpu_data = 8'hC3; cpu_req = 1'b1;
        expect_xact("t4_after", 1'b0, 4'h9, 8'hC3, 1'b0, 6);

        // 5: CPU request withdrawn during GAP1
        cpu_chip = 1'b0; cpu_reg = 4'h4; cpu_data = 8'h12; cpu_req = 1'b1;
        expect_xact("t5_drop", 1'b0, 4'h4, 8'h12, 1'b0, 3);
        tick();
        chk("t5_single_ack", obs(), ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12));

`ifdef YM_ADDR_CACHE_EN
        // 6: repeated chip0 reg3 skips the address phase; new reg restores it
        cpu_chip = 1'b0; cpu_reg = 4'h3; cpu_data = 8'h11; cpu_req = 1'b1;
        expect_xact("t6_first", 1'b0, 4'h3, 8'h11, 1'b0, 0);
        cpu_data = 8'h22;
        expect_fast("t6_hit", 1'b0, 8'h22, 3);
        cpu_reg = 4'h6; cpu_data = 8'h33; cpu_req = 1'b1;
        expect_xact("t6_miss", 1'b0, 4'h6, 8'h33, 1'b0, 6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
